write_port_arbiter: RTL and testbench
=====================================

Name: write_port_arbiter

Overview:
- Upstream stage for single-register write targets: N writers contend for one register and must never write it in the same cycle.
- Arbitrates N valid/ready write requests round-robin and issues exactly one registered write strobe per cycle (wr_en, wr_data, wr_src) to the downstream register.
- Counts contention cycles for debug visibility.

Parameters:
- NREQ, 2, number of requesting writers (>=1).
- DW, 1, write data width per requester.
- CW, 8, width of the contention counter.
- SW, $clog2(NREQ) with minimum 1, width of source id (derived, not overridable).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester write request.
- req_data  in  NREQ*DW  packed request data; requester k at [k*DW +: DW].
- req_ready  out  NREQ  one-hot grant; combinational from req_valid and the priority pointer.
- wr_en  out  1  registered write strobe to target register.
- wr_data  out  DW  registered data of the granted request.
- wr_src  out  SW  registered index of the granted requester.
- conflict_cnt  out  CW  number of cycles with two or more valid requests, saturating.
- conflict_sat  out  1  sticky flag, set when conflict_cnt reaches all-ones.

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_en=0, wr_data=0, wr_src=0, conflict_cnt=0, conflict_sat=0.
  - Priority pointer set so requester 0 has highest priority.
  - While rst=1, req_ready is all zero and no handshake occurs.
- Grant:
  - Search starts at the pointer index, proceeds ascending with wrap from NREQ-1 to 0.
  - First index with req_valid=1 wins. req_ready has exactly that bit set.
  - If no request is valid, req_ready=0.
- Handshake:
  - A transfer occurs when req_valid[k] & req_ready[k]. At most one transfer per cycle.
  - Requesters hold valid and data until ready. The arbiter tolerates valid dropping without a grant; that request is simply not served.
- Latency: 1 cycle. After a transfer from k at edge t, wr_en=1, wr_data=req_data[k], wr_src=k during cycle t+1. With no transfer, wr_en=0 and wr_data/wr_src hold their previous values.
- Pointer update: on a transfer from k, the pointer becomes (k+1) mod NREQ. With no transfer it is unchanged.
  - A lone requester is granted every cycle (throughput 1/cycle).
  - With all NREQ requesting continuously, grants rotate 0,1,...,NREQ-1,0,...
- Contention:
  - When popcount(req_valid) >= 2 and rst=0, conflict_cnt increments by 1.
  - At all-ones it holds (no wrap). conflict_sat is set in the same edge the counter becomes all-ones and stays set until rst.
- NREQ=1: req_ready = req_valid & !rst, wr_src always 0, conflict_cnt stays 0.
- Reset mid-stream: a transfer pending in the output register is discarded. wr_en is 0 in the cycle after the rst edge, and arbitration restarts from requester 0.
- Invariant for assertions: $onehot0(req_ready) every cycle. wr_en implies the previous cycle had exactly one handshake.

Decomposition:
- Shared package: SW derivation function (clog2 with floor 1), and a popcount-ge-2 helper function used by both this block and its checkers.
- One natural sub-module: rr_pick, a purely combinational rotate-priority picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded index, any.
  - Reusable by other arbitration points.
- The top holds the pointer, the output registers and the counter.

Test Plan:
- Reset check: rst=1 for 2 cycles with req_valid=all ones -> req_ready=0, wr_en=0, conflict_cnt=0 throughout; first post-reset grant goes to requester 0.
- Single requester (NREQ=2): req_valid=2'b10, req_data[1]=1 for 4 cycles -> req_ready=2'b10 each cycle; wr_en=1, wr_data=1, wr_src=1 from cycle 2 to 5; conflict_cnt=0.
- Full contention, NREQ=3, DW=4: all valid, data 0xA/0xB/0xC held for 6 cycles -> wr_src sequence 0,1,2,0,1,2 with matching wr_data; conflict_cnt=6.
- Pointer persistence: grant 0, idle 3 cycles, then both valid -> requester 1 granted first; wr_en=0 during the idle cycles, with wr_data/wr_src holding their previous values.
- Saturation, CW=2: 5 contention cycles -> conflict_cnt 1,2,3,3,3; conflict_sat rises with the value 3 and stays set after contention stops, until rst.
- Reset mid-stream: handshake at edge t, rst=1 at edge t+1 -> wr_en=0 after t+1; on release with both valid, requester 0 granted.

Source files
------------

// File: rtl/write_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : write_port_arbiter_pkg
//  Description : Shared helpers for the write-port arbiter and its checkers:
//                source-id width derivation and a contention test.
//  Revision    : 1.0 - initial release
// ============================================================================
package write_port_arbiter_pkg;

    // Width of an index into n requesters, never narrower than one bit.
    function automatic int sw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // True when at least two bits of v are set (clearing the lowest set bit
    // leaves something behind). Vectors up to 64 bits, zero-extended.
    function automatic logic popcnt_ge2(input logic [63:0] v);
        return (v & (v - 64'd1)) != 64'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/write_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : write_port_arbiter_rr_pick
//  Description : Combinational rotate-priority picker. Searches req upward
//                from ptr, wrapping at NREQ-1, and returns the first hit as
//                a one-hot grant plus its encoded index.
//  Revision    : 1.0 - initial release
// ============================================================================
module write_port_arbiter_rr_pick
    import write_port_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int SW  = sw_of(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [SW-1:0]   idx,
    output logic            any
);

    int w_k;

    // First requester at or after ptr (circularly) wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        w_k = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_k = int'(ptr) + i;
            if (w_k >= NREQ) begin
                w_k = w_k - NREQ;
            end
            if (!any && req[w_k]) begin
                any      = 1'b1;
                idx      = SW'(w_k);
                gnt[w_k] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/write_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : write_port_arbiter
//  Description : Round-robin arbiter in front of a single-register write
//                target. One registered write strobe per cycle, plus a
//                saturating count of cycles with competing requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module write_port_arbiter
    import write_port_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = 1,
    parameter int CW   = 8,
    localparam int SW  = sw_of(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wr_en,
    output logic [DW-1:0]        wr_data,
    output logic [SW-1:0]        wr_src,
    output logic [CW-1:0]        conflict_cnt,
    output logic                 conflict_sat
);

    localparam logic [SW-1:0] c_last    = SW'(NREQ - 1);
    localparam logic [CW-1:0] c_cnt_max = '1;

    logic [SW-1:0]   r_ptr;
    logic [NREQ-1:0] w_gnt;
    logic [SW-1:0]   w_idx;
    logic            w_any;
    logic            w_xfer;
    logic            w_conflict;
    logic            r_wr_en;
    logic [DW-1:0]   r_wr_data;
    logic [SW-1:0]   r_wr_src;
    logic [CW-1:0]   r_cnt;
    logic            r_sat;

    write_port_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_idx),
        .any (w_any)
    );

    // Grants are suppressed during reset so no handshake can slip through;
    // any grant given is by construction a transfer (valid is set).
    always_comb begin
        req_ready  = rst ? '0 : w_gnt;
        w_xfer     = w_any && !rst;
        w_conflict = popcnt_ge2(64'(req_valid));
    end

    // Priority pointer: the requester after the last winner goes first next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_idx == c_last) ? '0 : w_idx + 1'b1;
        end
    end

    // Output register: strobe for one cycle per transfer, data/src hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_wr_src  <= '0;
        end else begin
            r_wr_en <= w_xfer;
            if (w_xfer) begin
                r_wr_data <= req_data[w_idx*DW +: DW];
                r_wr_src  <= w_idx;
            end
        end
    end

    // Saturating contention counter with a sticky flag raised on reaching max.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_conflict && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_cnt_max - 1'b1) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign wr_en        = r_wr_en;
    assign wr_data      = r_wr_data;
    assign wr_src       = r_wr_src;
    assign conflict_cnt = r_cnt;
    assign conflict_sat = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_write_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_write_port_arbiter
//  Description : Scoreboard bench for write_port_arbiter (NREQ=3, DW=4, CW=3).
//                Driver computes expected grants and pushes expected writes;
//                monitor pops and compares what the DUT presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_write_port_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 4;
    localparam int CW   = 3;
    localparam int SW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                wr_en;
    logic [DW-1:0]       wr_data;
    logic [SW-1:0]       wr_src;
    logic [CW-1:0]       conflict_cnt;
    logic                conflict_sat;

    write_port_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .CW   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_src       (wr_src),
        .conflict_cnt (conflict_cnt),
        .conflict_sat (conflict_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int data;
        int src;
    } wr_t;

    typedef struct {
        bit rst_edge;
        int cnt;
        bit sat;
    } st_t;

    wr_t wq[$];
    st_t sq[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int  m_next = 0;   // requester that has first claim next cycle
    int  m_cnt  = 0;
    bit  m_sat  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    // One cycle of stimulus: drive at negedge, check the grant, predict the edge.
    task automatic step(input bit r, input logic [NREQ-1:0] v, input int d0, input int d1, input int d2);
        int d[NREQ];
        int win;
        int exp_rdy;
        wr_t w;
        st_t s;
        @(negedge clk);
        d[0] = d0; d[1] = d1; d[2] = d2;
        rst       = r;
        req_valid = v;
        for (int k = 0; k < NREQ; k++) req_data[k*DW +: DW] = DW'(d[k]);
        #1;
        win = -1;
        if (!r) begin
            for (int i = 0; i < NREQ; i++) begin
                if (win < 0 && v[(m_next + i) % NREQ]) win = (m_next + i) % NREQ;
            end
        end
        exp_rdy = (win >= 0) ? (1 << win) : 0;
        check("req_ready", int'(req_ready), exp_rdy);
        if (r) begin
            m_next = 0; m_cnt = 0; m_sat = 1'b0;
        end else begin
            if (win >= 0) begin
                w.due = cyc + 1; w.data = d[win]; w.src = win;
                wq.push_back(w);
                m_next = (win + 1) % NREQ;
            end
            if ($countones(v) >= 2 && m_cnt < CMAX) m_cnt++;
            if (m_cnt == CMAX) m_sat = 1'b1;
        end
        s.rst_edge = r; s.cnt = m_cnt; s.sat = m_sat;
        sq.push_back(s);
    endtask

    // Monitor: after each edge, compare the write port and debug counter.
    initial begin
        int last_d = 0;
        int last_s = 0;
        st_t s;
        wr_t w;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() != 0) begin
                s = sq.pop_front();
                if (s.rst_edge) begin
                    check("wr_en_rst", int'(wr_en), 0);
                    check("wr_data_rst", int'(wr_data), 0);
                    check("wr_src_rst", int'(wr_src), 0);
                    last_d = 0; last_s = 0;
                end else if (wq.size() != 0 && wq[0].due == cyc) begin
                    w = wq.pop_front();
                    check("wr_en", int'(wr_en), 1);
                    check("wr_data", int'(wr_data), w.data);
                    check("wr_src", int'(wr_src), w.src);
                    last_d = w.data; last_s = w.src;
                end else begin
                    check("wr_en_idle", int'(wr_en), 0);
                    check("wr_data_hold", int'(wr_data), last_d);
                    check("wr_src_hold", int'(wr_src), last_s);
                end
                check("conflict_cnt", int'(conflict_cnt), s.cnt);
                check("conflict_sat", int'(conflict_sat), int'(s.sat));
            end
        end
    end

    // Invariant: never more than one grant.
    always @(negedge clk) begin
        if (!$onehot0(req_ready)) begin
            n_bad++;
            $display("FAIL onehot0 at cycle %0d: req_ready=%b, required at most one bit", cyc, req_ready);
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;

        // Reset held with everyone requesting
        step(1, 3'b111, 1, 2, 3);
        step(1, 3'b111, 1, 2, 3);
        // First post-reset grant goes to requester 0
        step(0, 3'b111, 4, 5, 6);
        step(1, 3'b000, 0, 0, 0);
        // Lone requester 1, every cycle
        repeat (4) step(0, 3'b010, 0, 1, 0);
        step(1, 3'b000, 0, 0, 0);
        // Full contention: rotates 0,1,2,0,1,2
        repeat (6) step(0, 3'b111, 'hA, 'hB, 'hC);
        // Pointer persistence: grant 0, idle 3, then 0 and 1 -> 1 first
        step(0, 3'b001, 7, 0, 0);
        repeat (3) step(0, 3'b000, 0, 0, 0);
        step(0, 3'b011, 8, 9, 0);
        // Push counter past saturation, then idle: flag must stick
        repeat (4) step(0, 3'b101, 3, 0, 5);
        repeat (2) step(0, 3'b000, 0, 0, 0);
        // Reset mid-stream: transfer then rst; restart from requester 0
        step(0, 3'b100, 0, 0, 'hE);
        step(1, 3'b111, 1, 1, 1);
        step(0, 3'b011, 2, 3, 0);
        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0), 3'($urandom),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
        step(0, 3'b000, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("wq_drained", wq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
